// File: rtl/bw_mult_pkg.sv
// Shared FSM encoding and default operand widths for the Baugh-Wooley
// sequential multiplier.
package bw_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_AW = 7;
    localparam int DEF_BW = 5;

endpackage

// File: rtl/bw_pp_row.sv
// Combinational row step: adds one (optionally Baugh-Wooley modified) partial
// product row, shifted to its weight, into the running accumulator.
module bw_pp_row #(
    parameter int AW = 7,
    parameter int BW = 5,
    parameter int CW = $clog2(BW)
) (
    input  logic [AW-1:0]    a,
    input  logic             b_bit,
    input  logic [CW-1:0]    row,
    input  logic             t,
    input  logic [AW+BW-1:0] acc,
    output logic [AW+BW-1:0] acc_next
);

    localparam int W = AW + BW;
    localparam logic [W-1:0] ONE  = W'(1);
    // Summed, not OR-ed: when AW == BW the two low terms carry into 2^AW.
    localparam logic [W-1:0] CORR = (ONE << (AW - 1)) + (ONE << (BW - 1)) + (ONE << (W - 1));

    logic [AW-1:0] pp;
    logic          last_row;
    logic [W-1:0]  shifted;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        last_row = (row == CW'(BW - 1));
        for (int i = 0; i < AW; i++) begin
            pp[i] = a[i] & b_bit;
            // Complement terms that pair exactly one sign bit with a magnitude bit.
            if (t && ((i == AW - 1) != last_row)) begin
                pp[i] = ~pp[i];
            end
        end
        shifted  = W'(pp) << row;
        acc_next = acc + shifted + ((t && row == '0) ? CORR : '0);
    end

endmodule

// File: rtl/bw_seq_mult.sv
// Sequential signed/unsigned multiplier: one partial-product row per RUN cycle,
// product registered and pulsed with done after the last row.
module bw_seq_mult
    import bw_mult_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int BW = DEF_BW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    A,
    input  logic [BW-1:0]    B,
    input  logic             T,
    output logic             busy,
    output logic             done,
    output logic [AW+BW-1:0] out
);

    localparam int W  = AW + BW;
    localparam int CW = $clog2(BW);
    localparam logic [CW-1:0] LAST_ROW = CW'(BW - 1);

    state_t        state;
    logic [AW-1:0] a_reg;
    logic [BW-1:0] b_reg;
    logic          t_reg;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic [CW-1:0] row;

    bw_pp_row #(
        .AW(AW),
        .BW(BW),
        .CW(CW)
    ) u_row (
        .a       (a_reg),
        .b_bit   (b_reg[row]),
        .row     (row),
        .t       (t_reg),
        .acc     (acc),
        .acc_next(acc_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            t_reg <= 1'b0;
            acc   <= '0;
            row   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                        t_reg <= T;
                        acc   <= '0;
                        row   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (row == LAST_ROW) begin
                        // out only ever loads the finished sum.
                        out   <= acc_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        row <= row + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bw_seq_mult.md
BW_SEQ_MULT -- requirements
Module: bw_seq_mult

Interface
REQ-001 SHALL provide parameter AW, default 7, multiplicand A width; legal range 2..32.
REQ-002 SHALL provide parameter BW, default 5, multiplier B width; legal range 2..32.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a multiply.
REQ-006 SHALL have port A  input  AW  multiplicand.
REQ-007 SHALL have port B  input  BW  multiplier.
REQ-008 SHALL have port T  input  1  mode: 1 = both operands two's-complement (Baugh-Wooley), 0 = both unsigned.
REQ-009 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid product.
REQ-011 SHALL have port out  output  AW+BW  product register.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; accepting captures A, B and T into internal registers, clears the accumulator and row counter, and enters RUN.
REQ-014 SHALL ignore start while in RUN, with no effect on operands, mode or result.
REQ-015 SHALL process one partial-product row per RUN cycle, rows 0..BW-1 in order; the row counter is clog2(BW) bits wide and never wraps past BW-1.
REQ-016 SHALL form rows Baugh-Wooley style when T=1:
- complement the terms A[AW-1]&B[j] for j<BW-1, and A[i]&B[BW-1] for i<AW-1;
- inject the correction constants 1 at weight AW-1, 1 at weight BW-1, and 1 at weight AW+BW-1.
REQ-017 SHALL form plain AND partial products when T=0.
REQ-018 SHALL leave RUN after row BW-1 and enter DONE; done=1 for exactly that one cycle, and out shows the final product in that cycle.
REQ-019 SHALL give a latency of exactly BW+1 rising edges from the start-accepting edge to the edge after which done is first high.
REQ-020 SHALL make out equal A*B modulo 2^(AW+BW), signed or unsigned per captured T; for AW+BW bits this is exact, with no overflow.
REQ-021 SHALL hold out stable from DONE until the next product completes; out SHALL NOT show intermediate sums.
REQ-022 SHALL go DONE->IDLE when start=0, and DONE->RUN when start=1 (back-to-back, no bubble).
REQ-023 SHALL keep busy=1 exactly in RUN; done and busy are never both high.
REQ-024 SHALL ignore changes on A, B and T after capture.

Reset
REQ-025 SHALL, when rst=1 at a rising edge (including mid-RUN), force state IDLE, busy=0, done=0, out=0, and clear the accumulator, counter and operand registers.
REQ-026 SHALL give rst priority over a coincident start; that start is discarded.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE/RUN/DONE) and the default AW/BW constants in a shared package, bw_mult_pkg.
REQ-028 SHALL use one sub-module, bw_pp_row. It is combinational: given the A register, one B bit, the row index, T and the accumulator, it outputs the next accumulator.
REQ-029 SHALL make bw_seq_mult instantiate bw_pp_row once, reused every cycle.

Verification
REQ-030 SHALL cover, at AW=7, BW=5, T=1: A=-64 (0x40), B=-16 (0x10), start -> after 6 edges done=1, out=0x400 (1024).
REQ-031 SHALL cover T=0: A=127, B=31 -> out=0xF61 (3937); and T=1: A=-64, B=15 -> out=0xC40 (-960).
REQ-032 SHALL cover T=1, A=63, B=-16 -> out=0xC10. Start is held high through DONE; a second operand pair is accepted in the DONE cycle, and its done follows 6 edges later.
REQ-033 SHALL cover rst asserted during RUN row 2 -> next cycle busy=0, done=0, out=0; a fresh start then yields a correct product.
REQ-034 SHALL cover start pulsed during RUN with different A/B -> ignored; done timing and out match the first operands.
REQ-035 SHALL cover a randomised sweep at AW=BW=8 and AW=4, BW=9, both T values, checked against a reference model.
